// File: rtl/sm3_cmprss_core.sv
// SM3 compression core: one round per accepted (W_j, W'_j) transfer, 64 rounds per
// block, V chained across blocks, 256-bit digest presented with a one-cycle pulse.
module sm3_cmprss_core (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  cmprss_inpt_wj,
   input  logic [31:0]  cmprss_inpt_wjj,
   input  logic         cmprss_inpt_vld,
   input  logic         cmprss_inpt_lst,
   output logic         cmprss_inpt_rdy,
   output logic [255:0] cmprss_otpt_res,
   output logic         cmprss_otpt_vld
);

   typedef enum logic [1:0] {S_IDLE, S_RND, S_UPD, S_DONE} state_t;

   localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
   localparam logic [31:0]  TJ_LO = 32'h79cc4519;
   localparam logic [31:0]  TJ_HI = 32'h7a879d8a;

   function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
      logic [63:0] t;
      t = {x, x} << n;
      return t[63:32];
   endfunction

   function automatic logic [31:0] p0(input logic [31:0] x);
      return x ^ rotl(x, 5'd9) ^ rotl(x, 5'd17);
   endfunction

   state_t               state_q, state_d;
   // Word 7 is V0 / A, word 0 is V7 / H, so v_q is already the {V0..V7} digest layout.
   logic [7:0][31:0]     v_q, v_d;
   logic [7:0][31:0]     wrk_q, wrk_d;
   logic [5:0]           rnd_q, rnd_d;
   logic                 lst_q, lst_d;
   logic [255:0]         res_q, res_d;
   logic                 ovld_q, ovld_d;

   logic [31:0]          a, b, c, d, e, f, g, h;
   logic                 early;
   logic [31:0]          tj, a12, ss1, ss2, ff, gg, tt1, tt2;
   logic [7:0][31:0]     rnd_wrk;
   logic [7:0][31:0]     upd_v;
   logic                 xfer;

   assign cmprss_inpt_rdy = (state_q == S_IDLE) || (state_q == S_RND);
   assign cmprss_otpt_res = res_q;
   assign cmprss_otpt_vld = ovld_q;
   assign xfer            = cmprss_inpt_vld & cmprss_inpt_rdy;

   // Round datapath
   always_comb begin
      a     = wrk_q[7];
      b     = wrk_q[6];
      c     = wrk_q[5];
      d     = wrk_q[4];
      e     = wrk_q[3];
      f     = wrk_q[2];
      g     = wrk_q[1];
      h     = wrk_q[0];
      early = (rnd_q[5:4] == 2'b00);
      tj    = early ? TJ_LO : TJ_HI;
      a12   = rotl(a, 5'd12);
      ss1   = rotl(a12 + e + rotl(tj, rnd_q[4:0]), 5'd7);
      ss2   = ss1 ^ a12;
      ff    = early ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
      gg    = early ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1   = ff + d + ss2 + cmprss_inpt_wjj;
      tt2   = gg + h + ss1 + cmprss_inpt_wj;
      rnd_wrk = {tt1, a, rotl(b, 5'd9), c, p0(tt2), e, rotl(f, 5'd19), g};
      upd_v   = v_q ^ wrk_q;
   end

   // Control and next-state
   always_comb begin
      state_d = state_q;
      v_d     = v_q;
      wrk_d   = wrk_q;
      rnd_d   = rnd_q;
      lst_d   = lst_q;
      res_d   = res_q;
      ovld_d  = 1'b0;
      case (state_q)
         S_IDLE, S_RND: begin
            if (xfer) begin
               wrk_d   = rnd_wrk;
               rnd_d   = rnd_q + 6'd1;
               state_d = S_RND;
               if (rnd_q == 6'd63) begin
                  lst_d   = cmprss_inpt_lst;
                  state_d = S_UPD;
               end
            end
         end
         S_UPD: begin
            v_d   = upd_v;
            wrk_d = upd_v;
            if (lst_q) begin
               state_d = S_DONE;
               res_d   = upd_v;
               ovld_d  = 1'b1;
            end else begin
               state_d = S_RND;
            end
         end
         S_DONE: begin
            v_d     = IV;
            wrk_d   = IV;
            rnd_d   = 6'd0;
            lst_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         v_q     <= IV;
         wrk_q   <= IV;
         rnd_q   <= 6'd0;
         lst_q   <= 1'b0;
         res_q   <= '0;
         ovld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         v_q     <= v_d;
         wrk_q   <= wrk_d;
         rnd_q   <= rnd_d;
         lst_q   <= lst_d;
         res_q   <= res_d;
         ovld_q  <= ovld_d;
      end
   end

endmodule

// File: tb/tb_sm3_cmprss_core.sv
// Randomized bench for sm3_cmprss_core: a loop-based SM3 model computes each digest
// and its pulse cycle; one negedge monitor checks every output cycle against it.
module tb_sm3_cmprss_core;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  wj, wjj;
   logic         ivld, lst;
   logic         rdy;
   logic [255:0] res;
   logic         ovld;

   always #5 clk = ~clk;

   sm3_cmprss_core dut (
      .clk(clk), .rst(rst),
      .cmprss_inpt_wj(wj), .cmprss_inpt_wjj(wjj),
      .cmprss_inpt_vld(ivld), .cmprss_inpt_lst(lst),
      .cmprss_inpt_rdy(rdy),
      .cmprss_otpt_res(res), .cmprss_otpt_vld(ovld)
   );

   localparam logic [255:0] D_ABC  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
   localparam logic [255:0] D_ABCD = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rdy_low = 0;
   int vld_cnt = 0;
   int vcyc_q[$];
   logic [255:0] exp_q[$];
   int           expc_q[$];
   logic [255:0] hold = '0;
   logic         prev_ovld = 1'b0;
   logic         rst_s = 1'b0;

   logic [31:0] msg [4][16];
   logic [31:0] iv  [8] = '{32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
                            32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e};

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_s <= rst;
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      int s;
      s = n % 32;
      if (s == 0) return x;
      return (x << s) | (x >> (32 - s));
   endfunction

   function automatic logic [31:0] p0f(input logic [31:0] x);
      return x ^ rl(x, 9) ^ rl(x, 17);
   endfunction

   function automatic logic [31:0] p1f(input logic [31:0] x);
      return x ^ rl(x, 15) ^ rl(x, 23);
   endfunction

   function automatic logic [67:0][31:0] expand(input int blk);
      logic [67:0][31:0] w;
      for (int j = 0; j < 16; j++) w[j] = msg[blk][j];
      for (int j = 16; j < 68; j++)
         w[j] = p1f(w[j-16] ^ w[j-9] ^ rl(w[j-3], 15)) ^ rl(w[j-13], 7) ^ w[j-6];
      return w;
   endfunction

   // Straight-line SM3 compression over nb blocks of msg.
   function automatic logic [255:0] ref_digest(input int nb);
      logic [31:0] v[8], r[8];
      logic [67:0][31:0] w;
      logic [31:0] t, ss1, ss2, ff, gg, tt1, tt2;
      for (int k = 0; k < 8; k++) v[k] = iv[k];
      for (int bi = 0; bi < nb; bi++) begin
         w = expand(bi);
         r = v;
         for (int j = 0; j < 64; j++) begin
            t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
            ss1 = rl(rl(r[0], 12) + r[4] + rl(t, j), 7);
            ss2 = ss1 ^ rl(r[0], 12);
            ff  = (j < 16) ? (r[0] ^ r[1] ^ r[2]) : ((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
            gg  = (j < 16) ? (r[4] ^ r[5] ^ r[6]) : ((r[4] & r[5]) | (~r[4] & r[6]));
            tt1 = ff + r[3] + ss2 + (w[j] ^ w[j+4]);
            tt2 = gg + r[7] + ss1 + w[j];
            r[3] = r[2]; r[2] = rl(r[1], 9); r[1] = r[0]; r[0] = tt1;
            r[7] = r[6]; r[6] = rl(r[5], 19); r[5] = r[4]; r[4] = p0f(tt2);
         end
         for (int k = 0; k < 8; k++) v[k] = v[k] ^ r[k];
      end
      return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
   endfunction

   // Output monitor: every negedge after the first clock edge.
   always @(negedge clk) begin
      if (rdy === 1'b0) rdy_low++;
      if (rst_s) begin
         chk("rst_res", res, '0);
         chki("rst_vld", int'(ovld), 0);
         chki("rst_rdy", int'(rdy), 1);
         hold = '0;
      end else if (ovld === 1'b1) begin
         vld_cnt++;
         vcyc_q.push_back(cyc);
         if (prev_ovld) chki("vld_width", 2, 1);
         chki("done_rdy", int'(rdy), 0);
         if (exp_q.size() == 0) begin
            chki("spurious_vld", 1, 0);
         end else begin
            hold = exp_q.pop_front();
            chk("digest", res, hold);
            chki("vld_cycle", cyc, expc_q.pop_front());
         end
      end else begin
         chki("vld_low", int'(ovld), 0);
         chk("res_hold", res, hold);
      end
      prev_ovld = ovld;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // noise: 0 none, 1 lst at rounds 10/40 of block 0, 2 random lst on non-final rounds.
   // abort_at >= 0 replaces that round of block 0 with a one-cycle reset.
   task automatic send_msg(input int nb, input int max_gap, input int noise, input int abort_at);
      logic [67:0][31:0] w;
      int gaps, c0, rl0, guard, gp;
      gaps = 0; c0 = -1; rl0 = 0;
      for (int bi = 0; bi < nb; bi++) begin
         w = expand(bi);
         for (int j = 0; j < 64; j++) begin
            if (bi == 0 && j == abort_at) begin
               ivld = 1'b0; lst = 1'b0; rst = 1'b1;
               tick();
               rst = 1'b0;
               return;
            end
            if (j != 0 && max_gap > 0) begin
               gp = $urandom_range(max_gap, 0);
               ivld = 1'b0;
               repeat (gp) tick();
               gaps += gp;
            end
            ivld = 1'b1;
            wj   = w[j];
            wjj  = w[j] ^ w[j+4];
            if (j == 63)          lst = (bi == nb - 1);
            else if (noise == 1)  lst = (bi == 0) && (j == 10 || j == 40);
            else if (noise == 2)  lst = 1'($urandom_range(1, 0));
            else                  lst = 1'b0;
            guard = 0;
            while (rdy !== 1'b1 && guard < 10) begin
               tick();
               guard++;
            end
            if (rdy !== 1'b1) chki("rdy_timeout", int'(rdy), 1);
            if (c0 < 0) begin
               c0  = cyc;
               rl0 = rdy_low;
            end
            if (bi == nb - 1 && j == 63) begin
               exp_q.push_back(ref_digest(nb));
               expc_q.push_back(c0 + 65 * nb + gaps);
            end
            tick();
         end
      end
      ivld = 1'b0;
      lst  = 1'b0;
      chki("rdy_low_in_msg", rdy_low - rl0, nb - 1);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 300) begin
         tick();
         guard++;
      end
      if (exp_q.size() != 0) begin
         chki("drain_timeout", exp_q.size(), 0);
         exp_q.delete();
         expc_q.delete();
      end
      repeat (2) tick();
   endtask

   task automatic load_abc();
      for (int k = 0; k < 16; k++) msg[0][k] = 32'h0;
      msg[0][0]  = 32'h61626380;
      msg[0][15] = 32'h00000018;
   endtask

   task automatic load_abcd2();
      for (int k = 0; k < 16; k++) begin
         msg[0][k] = 32'h61626364;
         msg[1][k] = 32'h0;
      end
      msg[1][0]  = 32'h80000000;
      msg[1][15] = 32'h00000200;
   endtask

   initial begin
      int nb, v1, v2;
      rst = 1'b1; ivld = 1'b0; lst = 1'b0; wj = '0; wjj = '0;
      repeat (3) tick();
      chki("reset_rdy", int'(rdy), 1);
      chki("reset_vld", int'(ovld), 0);
      chk("reset_res", res, '0);
      rst = 1'b0;
      tick();

      load_abc();
      chk("model_abc", ref_digest(1), D_ABC);
      send_msg(1, 0, 0, -1);
      drain();
      chk("abc_literal", res, D_ABC);

      load_abcd2();
      chk("model_abcd16", ref_digest(2), D_ABCD);
      send_msg(2, 0, 0, -1);
      drain();
      chk("abcd16_literal", res, D_ABCD);

      load_abc();
      send_msg(1, 5, 0, -1);
      drain();
      chk("abc_gaps_literal", res, D_ABC);

      load_abcd2();
      send_msg(2, 0, 1, -1);
      drain();
      chk("lst_noise_literal", res, D_ABCD);

      load_abc();
      send_msg(1, 0, 0, 30);
      chk("abort_res", res, '0);
      send_msg(1, 0, 0, -1);
      drain();
      chk("after_abort_literal", res, D_ABC);

      vcyc_q.delete();
      send_msg(1, 0, 0, -1);
      send_msg(1, 0, 0, -1);
      drain();
      chki("b2b_pulses", vcyc_q.size(), 2);
      if (vcyc_q.size() == 2) begin
         v1 = vcyc_q.pop_front();
         v2 = vcyc_q.pop_front();
         chki("b2b_spacing", v2 - v1, 66);
      end

      for (int m = 0; m < 6; m++) begin
         nb = $urandom_range(3, 1);
         for (int bi = 0; bi < nb; bi++)
            for (int k = 0; k < 16; k++) msg[bi][k] = $urandom;
         send_msg(nb, 3, 2, -1);
         drain();
      end

      chki("pulse_count", vld_cnt, 13);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/sm3_cmprss_core.md
# sm3_cmprss_core

SM3 compression stage sitting directly downstream of the message expansion core. Consumes the expanded word pairs (W_j, W'_j), one round per accepted transfer, running the 64-round SM3 compression function per 512-bit block and chaining V across blocks. After the final block of a message it presents the 256-bit digest with a one-cycle valid pulse. Its `cmprss_inpt_rdy` drives the expansion core's `expnd_otpt_ena`.

## Interface
- No parameters. The 32-bit word datapath is fixed; the bus-width options in `sm3_cfg.v` affect only the pad and expansion stages.
- `clk`  in  1  single clock. Everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset. One clock, synchronous reset, active-high.
- `cmprss_inpt_wj`  in  32  W_j for the current round.
- `cmprss_inpt_wjj`  in  32  W'_j = W_j ^ W_{j+4} for the current round.
- `cmprss_inpt_vld`  in  1  word pair valid.
- `cmprss_inpt_lst`  in  1  marks round 63 of the final block of the message.
- `cmprss_inpt_rdy`  out  1  compressor can accept a word pair this cycle.
- `cmprss_otpt_res`  out  256  digest, {V0..V7}, with V0 in bits [255:224].
- `cmprss_otpt_vld`  out  1  one-cycle pulse: `cmprss_otpt_res` is valid.

## Operation
- Transfer occurs when `cmprss_inpt_vld & cmprss_inpt_rdy`. Only transfers advance state. When `vld` is low, all registers hold.
- Registers:
  - V0..V7, the chaining value.
  - A..H, the working set.
  - 6-bit round counter `rnd`.
  - `lst_q`, the captured last flag.
  - 2-bit state.
- IV = 7380166f 4914b2b9 172442d7 da8a0600 a96f30bc 163138aa e38dee4d b0fb0e4e.
- States:
  - IDLE: `rdy` = 1, V = IV, A..H = IV, `rnd` = 0. The first transfer performs round 0 and moves to RND.
  - RND: `rdy` = 1. Each transfer performs round `rnd` and increments `rnd`.
    - A transfer at `rnd` = 63 captures `lst_q` = `cmprss_inpt_lst` and moves to UPD.
    - `rnd` wraps to 0.
  - UPD (1 cycle): `rdy` = 0. V_k ← V_k ^ {A..H}_k, and A..H ← the same new value.
    - If `lst_q` = 0, go to RND to start the next block.
    - If `lst_q` = 1, go to DONE.
  - DONE (1 cycle): `rdy` = 0 and `cmprss_otpt_vld` = 1.
    - `res` = V.
    - Next cycle: V, A..H ← IV, `rnd` = 0, go to IDLE.
- Round j (all additions mod 2^32, `<<<` = rotate left):
  - T_j = 79cc4519 for j < 16, otherwise 7a879d8a.
  - SS1 = ((A<<<12) + E + (T_j <<< (j mod 32))) <<< 7.
  - SS2 = SS1 ^ (A<<<12).
  - FF: j < 16 → X^Y^Z; otherwise (X&Y)|(X&Z)|(Y&Z).
  - GG: j < 16 → X^Y^Z; otherwise (X&Y)|(~X&Z).
  - TT1 = FF(A,B,C) + D + SS2 + W'_j.
  - TT2 = GG(E,F,G) + H + SS1 + W_j.
  - Update: D←C, C←B<<<9, B←A, A←TT1, H←G, G←F<<<19, F←E, E←P0(TT2).
  - P0(X) = X ^ (X<<<9) ^ (X<<<17).
- `cmprss_inpt_lst` is ignored on every transfer other than round 63.
- `cmprss_otpt_res` holds its value until the next DONE.

## Timing
- Reset values: `cmprss_inpt_rdy` = 1 (IDLE), `cmprss_otpt_vld` = 0, `cmprss_otpt_res` = 0. State = IDLE, V and A..H = IV, `rnd` = 0.
- Throughput is one round per cycle. With `vld` held high, a block takes 64 transfer cycles plus 1 UPD cycle.
- A final block adds 1 DONE cycle: `cmprss_otpt_vld` is high 2 cycles after the round-63 transfer edge.
- An N-block message with no stalls takes 65·N + 1 cycles from the first transfer to the `vld` pulse.
- Bubbles (`vld` = 0) in IDLE or RND insert exactly one cycle each. No rounds are lost or duplicated.
- `rdy` drops combinationally from state only, never from `vld`. Upstream must hold its word while `rdy` = 0.
- A `rst` asserted in any state, including mid-block or in DONE, aborts at the next edge to reset values. There is no output pulse for the aborted message.
- The IDLE entry following DONE can accept a transfer in the very next cycle (back-to-back messages).

## Test plan
- Single block "abc": drive the expanded W/W' of the padded block 61626380 00…00 00000018 with `lst` at round 63.
  - Expect `vld` 2 cycles after the last transfer.
  - Expect `res` = 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0.
- Two blocks, "abcd"×16 (512 bits) with `lst` on block 2 only:
  - Expect `res` = debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732.
  - Expect no `vld` after block 1.
  - Expect `rdy` low for exactly the 1 UPD cycle between the blocks.
- "abc" with random `vld` gaps (0–5 cycles) → same digest as the first scenario.
  - Check `rnd` advances only on transfers.
  - Check total cycles = 65 + gaps + 1.
- `lst` asserted at rounds 10 and 40 of the first block of the two-block message → ignored; the digest still equals the second-scenario value.
- Reset at round 30 of block 1, then a full "abc" run:
  - Expect `res` = 0 and `vld` = 0 during reset.
  - Then expect the first-scenario digest, proving V reloaded IV.
- Back-to-back: "abc" immediately followed by "abc" → two `vld` pulses 66 cycles apart, both with the first-scenario digest.
